// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction-fetch controller: fetch PC, ROM addressing, 2-entry
//            {pc, instr} buffer with valid/ready output and redirect/flush.
//            Optional perf counters enabled by `define FETCH_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_flush
`endif
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_ctrl: RESET_PC must be word-aligned");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 30) begin : g_bad_addr_bits
    $error("fetch_ctrl: ADDR_BITS out of range");
  end

  logic [31:0] fpc_q, fpc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic        fault_q, fault_d;

  logic pop;
  logic push;
  logic redir;

  assign pop   = (count_q != 2'd0) & out_ready;
  assign redir = redirect_valid & ~fault_q;
  assign push  = fetch_en & ~fault_q & ~redirect_valid & ((count_q != 2'd2) | pop);

  always_comb begin
    fpc_d   = fpc_q;
    count_d = count_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    ins0_d  = ins0_q;
    ins1_d  = ins1_q;
    fault_d = fault_q;

    if (redir) begin
      // Flush; a misaligned target halts fetch without moving the PC.
      count_d = 2'd0;
      if (redirect_pc[1:0] == 2'b00) begin
        fpc_d = redirect_pc;
      end else begin
        fault_d = 1'b1;
      end
    end else begin
      if (push) begin
        fpc_d = fpc_q + 32'd4;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_d  = fpc_q;
            ins0_d = im_instr;
          end else begin
            pc1_d  = fpc_q;
            ins1_d = im_instr;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          pc0_d   = pc1_q;
          ins0_d  = ins1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = fpc_q;
            ins1_d = im_instr;
          end else begin
            pc0_d  = fpc_q;
            ins0_d = im_instr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fpc_q   <= RESET_PC;
      count_q <= 2'd0;
      pc0_q   <= 32'd0;
      pc1_q   <= 32'd0;
      ins0_q  <= 32'd0;
      ins1_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      fpc_q   <= fpc_d;
      count_q <= count_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      ins0_q  <= ins0_d;
      ins1_q  <= ins1_d;
      fault_q <= fault_d;
    end
  end

  assign im_addr   = fpc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = out_valid ? pc0_q : 32'd0;
  assign out_instr = out_valid ? ins0_q : 32'd0;
  assign fault     = fault_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, push & ~redir};
    perf_stall_d = perf_stall_q + {31'd0, out_valid & ~out_ready};
    perf_flush_d = perf_flush_q + {15'd0, redir};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
      perf_flush_q <= 16'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Self-checking bench for fetch_ctrl against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  always #5 clk = ~clk;

  logic [31:0] rom [0:1023];
  assign im_instr = rom[im_addr[11:2]];

  fetch_ctrl #(.RESET_PC(RESET_PC), .ADDR_BITS(10)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault          (fault)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetch     (perf_fetch),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: fetched words in order, the fetch PC and the fault flag.
  ent_t        mq[$];
  logic [31:0] m_fpc = RESET_PC;
  bit          m_fault = 1'b0;
  logic [31:0] m_pf = 32'd0;
  logic [31:0] m_ps = 32'd0;
  logic [15:0] m_pfl = 16'd0;

  ent_t got[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [97:0] exp_vec();
    logic        v;
    logic [31:0] p;
    logic [31:0] i;
    v = (mq.size() > 0);
    p = v ? mq[0].pc : 32'd0;
    i = v ? mq[0].instr : 32'd0;
    return {v, p, i, m_fpc, m_fault};
  endfunction

  task automatic cyc();
    ent_t        nq[$];
    logic [31:0] nf;
    bit          nfault;
    bit          pop, push, redir;
    logic [31:0] npf, nps;
    logic [15:0] npfl;
    nq     = mq;
    nf     = m_fpc;
    nfault = m_fault;
    npf    = m_pf;
    nps    = m_ps;
    npfl   = m_pfl;
    if (out_valid && out_ready) got.push_back({out_pc, out_instr});
    if (!reset_n) begin
      nq.delete();
      nf = RESET_PC; nfault = 1'b0;
      npf = 32'd0; nps = 32'd0; npfl = 16'd0;
    end else begin
      pop   = (mq.size() > 0) && out_ready;
      redir = redirect_valid && !m_fault;
      push  = fetch_en && !m_fault && !redirect_valid && (mq.size() < 2 || pop);
      if (mq.size() > 0 && !out_ready) nps = nps + 1;
      if (pop) void'(nq.pop_front());
      if (redir) begin
        nq.delete();
        npfl = npfl + 1;
        if (redirect_pc[1:0] == 2'b00) nf = redirect_pc;
        else nfault = 1'b1;
      end else if (push) begin
        nq.push_back({m_fpc, rom[m_fpc[11:2]]});
        nf  = m_fpc + 32'd4;
        npf = npf + 1;
      end
    end
    @(posedge clk);
    #1;
    mq = nq; m_fpc = nf; m_fault = nfault;
    m_pf = npf; m_ps = nps; m_pfl = npfl;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    for (int c = 0; c < 2; c++) begin
      cyc();
      tests++;
      if ({out_valid, out_pc, out_instr, im_addr, fault} !== {1'b0, 32'd0, 32'd0, RESET_PC, 1'b0}) begin
        fails++;
        $display("FAIL reset_state: got v=%b pc=%h ins=%h addr=%h f=%b want 0/0/0/%h/0",
                 out_valid, out_pc, out_instr, im_addr, fault, RESET_PC);
      end
    end
    reset_n = 1'b1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL release_valid: got %b want 0", out_valid);
    end
    got.delete();
    for (int c = 0; c < 4; c++) begin
      cyc();
      tests++;
      if ({out_valid, out_pc, out_instr, im_addr, fault} !== exp_vec()) begin
        fails++;
        $display("FAIL freerun_model t=%0t: got %h want %h", $time,
                 {out_valid, out_pc, out_instr, im_addr, fault}, exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got.size() <= i || got[i] !== {32'h3000 + 32'(4 * i), 32'(8'h11 * (i + 1))}) begin
        fails++;
        $display("FAIL freerun_seq[%0d]: got %h want %h", i,
                 (got.size() > i) ? got[i] : 64'hx, {32'h3000 + 32'(4 * i), 32'(8'h11 * (i + 1))});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] start_pc;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      tests++;
      if ({out_valid, out_pc, out_instr, im_addr, fault} !== exp_vec()) begin
        fails++;
        $display("FAIL backpressure_hold t=%0t: got %h want %h", $time,
                 {out_valid, out_pc, out_instr, im_addr, fault}, exp_vec());
      end
    end
    start_pc = mq[0].pc;
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 6; c++) cyc();
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (got.size() <= i || got[i] !== {start_pc + 32'(4 * i), rom[10'((start_pc >> 2) + 32'(i))]}) begin
        fails++;
        $display("FAIL backpressure_resume[%0d]: got %h want pc %h", i,
                 (got.size() > i) ? got[i] : 64'hx, start_pc + 32'(4 * i));
      end
    end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      tests++;
      if (out_valid !== 1'b1 || {out_valid, out_pc, out_instr, im_addr, fault} !== exp_vec()) begin
        fails++;
        $display("FAIL full_pop t=%0t: got %h want %h", $time,
                 {out_valid, out_pc, out_instr, im_addr, fault}, exp_vec());
      end
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) cyc();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h3040;
    cyc();
    redirect_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || im_addr !== 32'h3040) begin
      fails++;
      $display("FAIL redirect_bubble: got v=%b addr=%h want v=0 addr=00003040", out_valid, im_addr);
    end
    cyc();
    tests++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h3040, rom[16]}) begin
      fails++;
      $display("FAIL redirect_target: got v=%b pc=%h ins=%h want 1/00003040/%h",
               out_valid, out_pc, out_instr, rom[16]);
    end
    got.delete();
    for (int c = 0; c < 4; c++) cyc();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got.size() <= i || got[i].pc !== 32'h3040 + 32'(4 * i)) begin
        fails++;
        $display("FAIL redirect_stream[%0d]: got %h want pc %h", i,
                 (got.size() > i) ? got[i] : 64'hx, 32'h3040 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] held;
    held = m_fpc;
    redirect_valid = 1'b1; redirect_pc = 32'h3042;
    cyc();
    redirect_valid = 1'b0;
    tests++;
    if ({fault, out_valid, im_addr} !== {1'b1, 1'b0, held}) begin
      fails++;
      $display("FAIL misaligned_fault: got f=%b v=%b addr=%h want 1/0/%h", fault, out_valid, im_addr, held);
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      tests++;
      if ({fault, out_valid, im_addr} !== {1'b1, 1'b0, held}) begin
        fails++;
        $display("FAIL misaligned_halt: got f=%b v=%b addr=%h want 1/0/%h", fault, out_valid, im_addr, held);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    cyc();
    redirect_valid = 1'b0;
    tests++;
    if ({fault, out_valid, im_addr} !== {1'b1, 1'b0, held}) begin
      fails++;
      $display("FAIL fault_ignores_redirect: got f=%b v=%b addr=%h want 1/0/%h", fault, out_valid, im_addr, held);
    end
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    tests++;
    if ({fault, im_addr} !== {1'b0, RESET_PC}) begin
      fails++;
      $display("FAIL fault_cleared: got f=%b addr=%h want 0/%h", fault, im_addr, RESET_PC);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; fetch_en = 1'b1;
    for (int c = 0; c < 3; c++) cyc();
    reset_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3100; out_ready = 1'b1;
    cyc();
    reset_n = 1'b1; redirect_valid = 1'b0;
    tests++;
    if ({out_valid, fault, im_addr, out_pc} !== {1'b0, 1'b0, RESET_PC, 32'd0}) begin
      fails++;
      $display("FAIL reset_midstream: got v=%b f=%b addr=%h pc=%h want 0/0/%h/0",
               out_valid, fault, im_addr, out_pc, RESET_PC);
    end
`ifdef FETCH_CTRL_PERF_EN
    tests++;
    if ({perf_fetch, perf_stall, perf_flush} !== 80'd0) begin
      fails++;
      $display("FAIL perf_reset: got %h/%h/%h want 0/0/0", perf_fetch, perf_stall, perf_flush);
    end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      reset_n        = ($urandom_range(0, 99) != 0);
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 32'h3000 + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 9) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      cyc();
      tests++;
      if ({out_valid, out_pc, out_instr, im_addr, fault} !== exp_vec()) begin
        fails++;
        $display("FAIL random_model cyc%0d: got %h want %h", c,
                 {out_valid, out_pc, out_instr, im_addr, fault}, exp_vec());
      end
`ifdef FETCH_CTRL_PERF_EN
      tests++;
      if ({perf_fetch, perf_stall, perf_flush} !== {m_pf, m_ps, m_pfl}) begin
        fails++;
        $display("FAIL random_perf cyc%0d: got %h/%h/%h want %h/%h/%h", c,
                 perf_fetch, perf_stall, perf_flush, m_pf, m_ps, m_pfl);
      end
`endif
    end
    reset_n = 1'b1; redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    reset_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    #1;
    test_reset();
    test_backpressure();
    test_full_pop();
    test_redirect();
    test_misaligned();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
